// File: rtl/pq_pkg.sv
// ---------------------------------------------------------------------------
// pq_pkg
// Shared types for the QuickQ priority-queue chain and its command arbiter.
//   kv_t            : queue entry (lower value = higher priority)
//   MAX_KEY         : all-ones entry, returned when a replace hits an empty queue
//   qq_op_t         : requester operation encoding
//   qq_arb_state_t  : arbiter sequencing states
// ---------------------------------------------------------------------------
package pq_pkg;
    localparam int KW = 16;

    typedef logic [KW-1:0] kv_t;

    localparam kv_t MAX_KEY = '1;

    typedef enum logic [1:0] {
        OP_ENQ  = 2'b00,
        OP_DEQ  = 2'b01,
        OP_REPL = 2'b10
    } qq_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } qq_arb_state_t;
endpackage

// File: rtl/qq_rr_pick.sv
// ---------------------------------------------------------------------------
// qq_rr_pick
// Combinational round-robin selector: returns the first set request found
// scanning upward from ptr_i, wrapping modulo NREQ.
// Ports:
//   req_i  : request vector
//   ptr_i  : highest-priority index this round
//   vld_o  : at least one request present
//   win_o  : selected requester index
// ---------------------------------------------------------------------------
module qq_rr_pick #(
    parameter int NREQ = 4,
    parameter int RW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [RW-1:0]   ptr_i,
    output logic            vld_o,
    output logic [RW-1:0]   win_o
);
    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [RW:0] idx;

    always_comb begin
        vld_o = |req_i;
        win_o = '0;
        idx   = '0;
        // Walk offsets from farthest to nearest so the nearest set request
        // (lowest offset from ptr) is the last one written.
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = {1'b0, ptr_i} + (RW + 1)'(off);
            if (idx >= (RW + 1)'(NREQ)) idx = idx - (RW + 1)'(NREQ);
            if (req_i[idx[RW-1:0]]) win_o = idx[RW-1:0];
        end
    end
endmodule

// File: rtl/qq_arbiter.sv
// ---------------------------------------------------------------------------
// qq_arbiter
// Round-robin command arbiter in front of the QuickQ node chain. One
// operation is outstanding at a time: IDLE accepts a winner, ISSUE pulses
// one queue strobe, BUSY waits for the queue to return to rdy, RESP pulses
// done_o to the winner. Illegal operations skip straight to RESP with err_o.
// Optional build macro: QQ_ARB_STATS_EN adds saturating 16-bit counters
// stat_enq_o / stat_deq_o / stat_err_o.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   req_i/op_i/key_i      : per-requester command, held until done_o
//   done_o/err_o/resp_o   : one-hot completion, reject flag, removed head
//   q_rdy_i/q_full_i/q_empty_i/q_head_i : queue status
//   q_enq_o/q_deq_o/q_repl_o/q_data_o   : queue command strobes and data
//   busy_o                : operation in progress
// ---------------------------------------------------------------------------
module qq_arbiter
    import pq_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0][1:0]     op_i,
    input  logic [NREQ-1:0][KW-1:0]  key_i,
    output logic [NREQ-1:0]          done_o,
    output logic                     err_o,
    output kv_t                      resp_o,
    input  logic                     q_rdy_i,
    input  logic                     q_full_i,
    input  logic                     q_empty_i,
    input  kv_t                      q_head_i,
    output logic                     q_enq_o,
    output logic                     q_deq_o,
    output logic                     q_repl_o,
    output kv_t                      q_data_o,
`ifdef QQ_ARB_STATS_EN
    output logic [15:0]              stat_enq_o,
    output logic [15:0]              stat_deq_o,
    output logic [15:0]              stat_err_o,
`endif
    output logic                     busy_o
);
    localparam int RW = $clog2(NREQ);

    qq_arb_state_t   state_q;
    logic [RW-1:0]   rr_ptr_q, rr_ptr_d, win_q;
    qq_op_t          op_q;
    kv_t             key_q, resp_q;
    logic [NREQ-1:0] done_q;
    logic            err_q, enq_q, deq_q, repl_q, busy_q;

    logic            pick_vld;
    logic [RW-1:0]   pick_win;
    qq_op_t          sel_op;
    logic            sel_rej;

    qq_rr_pick #(.NREQ(NREQ), .RW(RW)) u_pick (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .vld_o (pick_vld),
        .win_o (pick_win)
    );

    always_comb begin
        sel_op   = qq_op_t'(op_i[pick_win]);
        rr_ptr_d = (pick_win == RW'(NREQ - 1)) ? '0 : pick_win + 1'b1;
        // Unknown encodings fall into the default arm and are rejected.
        case (sel_op)
            OP_ENQ:  sel_rej = q_full_i;
            OP_DEQ:  sel_rej = q_empty_i;
            OP_REPL: sel_rej = 1'b0;
            default: sel_rej = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            op_q     <= OP_ENQ;
            key_q    <= '0;
            resp_q   <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            enq_q    <= 1'b0;
            deq_q    <= 1'b0;
            repl_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            done_q <= '0;
            err_q  <= 1'b0;
            enq_q  <= 1'b0;
            deq_q  <= 1'b0;
            repl_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld && q_rdy_i) begin
                        win_q    <= pick_win;
                        op_q     <= sel_op;
                        key_q    <= key_i[pick_win];
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b1;
                        if (sel_rej) begin
                            state_q <= RESP;
                            done_q  <= NREQ'(1) << pick_win;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            enq_q   <= (sel_op == OP_ENQ);
                            deq_q   <= (sel_op == OP_DEQ);
                            repl_q  <= (sel_op == OP_REPL);
                        end
                    end
                end
                ISSUE: begin
                    // Head is still the pre-operation minimum on this edge.
                    if (op_q == OP_ENQ)
                        resp_q <= '0;
                    else if (q_empty_i)
                        resp_q <= MAX_KEY;
                    else
                        resp_q <= q_head_i;
                    state_q <= BUSY;
                end
                BUSY: begin
                    if (q_rdy_i) begin
                        state_q <= RESP;
                        done_q  <= NREQ'(1) << win_q;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    resp_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_o   = done_q;
    assign err_o    = err_q;
    assign resp_o   = resp_q;
    assign q_enq_o  = enq_q;
    assign q_deq_o  = deq_q;
    assign q_repl_o = repl_q;
    assign q_data_o = key_q;
    assign busy_o   = busy_q;

`ifdef QQ_ARB_STATS_EN
    logic [15:0] st_enq_q, st_deq_q, st_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_enq_q <= '0;
            st_deq_q <= '0;
            st_err_q <= '0;
        end else if (state_q == RESP) begin
            if (err_q) begin
                if (st_err_q != 16'hFFFF) st_err_q <= st_err_q + 16'd1;
            end else if (op_q == OP_ENQ) begin
                if (st_enq_q != 16'hFFFF) st_enq_q <= st_enq_q + 16'd1;
            end else begin
                if (st_deq_q != 16'hFFFF) st_deq_q <= st_deq_q + 16'd1;
            end
        end
    end

    assign stat_enq_o = st_enq_q;
    assign stat_deq_o = st_deq_q;
    assign stat_err_o = st_err_q;
`endif
endmodule

// File: tb/tb_qq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_qq_arbiter
// Directed bench for qq_arbiter with a behavioural QuickQ model (sorted
// list, rdy low for RDY_LAT cycles after each strobe). Expected responses
// and strobes are queued when stimulus is issued; a negedge monitor pops
// and compares whenever the DUT presents a done pulse or a strobe.
// ---------------------------------------------------------------------------
module tb_qq_arbiter;
    import pq_pkg::*;

    localparam int NREQ    = 4;
    localparam int CAP     = 16;
    localparam int RDY_LAT = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NREQ-1:0]         req_i;
    logic [NREQ-1:0][1:0]    op_i;
    logic [NREQ-1:0][KW-1:0] key_i;
    logic [NREQ-1:0]         done_o;
    logic                    err_o;
    kv_t                     resp_o;
    logic                    q_rdy_i, q_full_i, q_empty_i;
    kv_t                     q_head_i;
    logic                    q_enq_o, q_deq_o, q_repl_o;
    kv_t                     q_data_o;
    logic                    busy_o;
`ifdef QQ_ARB_STATS_EN
    logic [15:0]             stat_enq_o, stat_deq_o, stat_err_o;
`endif

    always #5 clk = ~clk;

    qq_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .op_i(op_i), .key_i(key_i),
        .done_o(done_o), .err_o(err_o), .resp_o(resp_o),
        .q_rdy_i(q_rdy_i), .q_full_i(q_full_i), .q_empty_i(q_empty_i),
        .q_head_i(q_head_i), .q_enq_o(q_enq_o), .q_deq_o(q_deq_o),
        .q_repl_o(q_repl_o), .q_data_o(q_data_o),
`ifdef QQ_ARB_STATS_EN
        .stat_enq_o(stat_enq_o), .stat_deq_o(stat_deq_o), .stat_err_o(stat_err_o),
`endif
        .busy_o(busy_o)
    );

    // ---------------- queue model ----------------
    kv_t  qm[$];
    int   lat_cnt = 0;
    int   qsize   = 0;
    kv_t  qhead   = '0;
    logic force_full  = 1'b0;
    logic force_empty = 1'b0;

    assign q_rdy_i   = (lat_cnt == 0);
    assign q_full_i  = force_full || (qsize >= CAP);
    assign q_empty_i = force_empty || (qsize == 0);
    // Empty queue shows 0 so a missing MAX substitution is visible.
    assign q_head_i  = (qsize == 0) ? '0 : qhead;

    always @(posedge clk) begin
        if (q_enq_o || q_deq_o || q_repl_o) begin
            int pos;
            lat_cnt <= RDY_LAT;
            if ((q_deq_o || q_repl_o) && qm.size() > 0) void'(qm.pop_front());
            if (q_enq_o || q_repl_o) begin
                pos = qm.size();
                for (int i = qm.size() - 1; i >= 0; i--)
                    if (qm[i] > q_data_o) pos = i;
                qm.insert(pos, q_data_o);
            end
            qsize <= qm.size();
            qhead <= (qm.size() > 0) ? qm[0] : '0;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { int idx; bit err; kv_t resp; } rsp_t;
    typedef struct { int kind; kv_t data; } stb_t;
    rsp_t exp_rsp[$];
    stb_t exp_stb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int nstb;
        nstb = int'(q_enq_o) + int'(q_deq_o) + int'(q_repl_o);
        if (nstb != 0) begin
            chk("strobe_count", 32'(nstb), 32'd1);
            if (exp_stb.size() == 0) begin
                chk("unexpected_strobe", {q_repl_o, q_deq_o, q_enq_o}, 3'b000);
            end else begin
                stb_t s;
                s = exp_stb.pop_front();
                chk("strobe_kind", {q_repl_o, q_deq_o, q_enq_o}, 32'(3'b001 << s.kind));
                if (s.kind != 1) chk("strobe_data", q_data_o, s.data);
            end
        end
        if (done_o != '0) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_done", done_o, 0);
            end else begin
                rsp_t r;
                r = exp_rsp.pop_front();
                chk("done_vec", done_o, 32'(4'b0001 << r.idx));
                chk("done_err", err_o, r.err);
                chk("done_resp", resp_o, r.resp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input int idx, input logic [1:0] op, input kv_t key,
                          input bit err, input kv_t resp, input int exp_lat);
        rsp_t r;
        stb_t s;
        int   n;
        bit   got;
        r.idx = idx; r.err = err; r.resp = resp;
        exp_rsp.push_back(r);
        if (!err) begin
            s.kind = int'(op); s.data = key;
            exp_stb.push_back(s);
        end
        @(negedge clk);
        req_i[idx] = 1'b1; op_i[idx] = op; key_i[idx] = key;
        n = 0; got = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (done_o[idx]) got = 1;
        end
        req_i[idx] = 1'b0;
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        else      chk("latency", 32'(n), 32'(exp_lat));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"},  err_o, 0);
        chk({tag, "_resp"}, resp_o, 0);
        chk({tag, "_stb"},  {q_enq_o, q_deq_o, q_repl_o}, 0);
        chk({tag, "_data"}, q_data_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_i = '0; op_i = '0; key_i = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Basic enqueue / dequeue / replace-on-empty.
        run_op(0, OP_ENQ,  16'd5, 0, 16'd0, 7);
        run_op(3, OP_DEQ,  16'd0, 0, 16'd5, 7);
        run_op(1, OP_REPL, 16'd9, 0, MAX_KEY, 7);
        run_op(2, OP_DEQ,  16'd0, 0, 16'd9, 7);

        // Queue {3,7}, dequeue returns 3.
        run_op(1, OP_ENQ,  16'd7, 0, 16'd0, 7);
        run_op(3, OP_ENQ,  16'd3, 0, 16'd0, 7);
        run_op(2, OP_DEQ,  16'd0, 0, 16'd3, 7);

        // Rejections: done on the cycle after accept, no strobe.
        force_full = 1'b1;
        run_op(1, OP_ENQ,  16'd8, 1, 16'd0, 1);
        force_full = 1'b0; force_empty = 1'b1;
        run_op(0, OP_DEQ,  16'd0, 1, 16'd0, 1);
        force_empty = 1'b0;
        run_op(3, 2'b11,   16'd4, 1, 16'd0, 1);

        // All four requesting continuously from rr_ptr=0: grants 0,1,2,3,0.
        begin
            int order [5] = '{0, 1, 2, 3, 0};
            int ndone, n;
            rsp_t r;
            stb_t s;
            for (int i = 0; i < 5; i++) begin
                r.idx = order[i]; r.err = 0; r.resp = '0;
                exp_rsp.push_back(r);
                s.kind = 0; s.data = kv_t'(16'h20 + order[i]);
                exp_stb.push_back(s);
            end
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                op_i[i] = OP_ENQ; key_i[i] = kv_t'(16'h20 + i);
            end
            req_i = 4'b1111;
            ndone = 0; n = 0;
            while (ndone < 5 && n < 200) begin
                @(negedge clk);
                n++;
                if (done_o != '0) ndone++;
                if (ndone == 5) req_i = '0;
            end
            req_i = '0;
            chk("rr_grant_count", 32'(ndone), 32'd5);
        end

        // Replace on a non-empty queue returns the old head (7).
        run_op(2, OP_REPL, 16'd1, 0, 16'd7, 7);

        // Reset while BUSY: operation abandoned, rr_ptr back to 0.
        begin
            stb_t s;
            int   n;
            s.kind = 0; s.data = 16'h55;
            exp_stb.push_back(s);
            @(negedge clk);
            req_i[1] = 1'b1; op_i[1] = OP_ENQ; key_i[1] = 16'h55;
            repeat (3) @(negedge clk);
            chk("busy_before_rst", busy_o, 1);
            rst_n = 1'b0; req_i = '0;
            @(negedge clk);
            chk_zero("midrst");
            rst_n = 1'b1;
            repeat (12) @(negedge clk);

            begin
                rsp_t r;
                r.idx = 0; r.err = 0; r.resp = '0; exp_rsp.push_back(r);
                r.idx = 2; exp_rsp.push_back(r);
                s.kind = 0; s.data = 16'h30; exp_stb.push_back(s);
                s.data = 16'h32; exp_stb.push_back(s);
            end
            op_i[0] = OP_ENQ; key_i[0] = 16'h30;
            op_i[2] = OP_ENQ; key_i[2] = 16'h32;
            req_i = 4'b0101;
            n = 0;
            while (req_i != '0 && n < 100) begin
                @(negedge clk);
                n++;
                req_i = req_i & ~done_o;
            end
            chk("post_rst_reqs_served", {28'd0, req_i}, 32'd0);
            req_i = '0;
        end

        repeat (4) @(negedge clk);
        chk("rsp_left", 32'(exp_rsp.size()), 32'd0);
        chk("stb_left", 32'(exp_stb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qq_arbiter.md
Name: qq_arbiter

Overview:
- Round-robin command arbiter that shares one QuickQ priority-queue node chain among NREQ requesters.
- Each requester posts one operation (enqueue, dequeue or replace) and holds it until a one-cycle done pulse.
- The arbiter sequences the queue's one-cycle enq/deq/repl strobes against its rdy handshake, rejects illegal operations (enqueue when full, dequeue when empty), and returns the dequeued/replaced head entry to the winner.
- Sits between client logic and the top node of the QuickQ chain.

Parameters:
- NREQ, 4, number of requesters (2..16)
- RW, $clog2(NREQ), width of the winner index (derived localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- req_i  in  NREQ  per-requester request, held high until that requester's done_o
- op_i  in  NREQ x qq_op_t  per-requester operation (OP_ENQ, OP_DEQ, OP_REPL)
- key_i  in  NREQ x kv_t  per-requester entry for OP_ENQ/OP_REPL
- done_o  out  NREQ  one-hot, one-cycle completion pulse
- err_o  out  1  qualifies done_o: operation rejected
- resp_o  out  kv_t  head entry removed by OP_DEQ/OP_REPL; valid with done_o
- q_rdy_i  in  1  queue idle and accepting a command
- q_full_i  in  1  queue full flag
- q_empty_i  in  1  queue empty flag
- q_head_i  in  kv_t  current minimum (address 0) entry of the queue
- q_enq_o  out  1  enqueue strobe
- q_deq_o  out  1  dequeue strobe
- q_repl_o  out  1  replace strobe
- q_data_o  out  kv_t  entry presented with q_enq_o/q_repl_o
- busy_o  out  1  operation in progress

Behaviour:
- Reset (rst_n=0 at a clock edge, including mid-operation):
  - state=IDLE; rr_ptr=0.
  - All outputs 0.
  - Any in-flight operation is abandoned with no done_o.
- IDLE:
  - Wait until any req_i is high and q_rdy_i=1.
  - Pick the winner by round-robin: the first set req_i scanning upward from rr_ptr, wrapping modulo NREQ.
  - Latch win_idx, op and key (q_data_o is driven from the latch).
  - Set rr_ptr=(win_idx+1) mod NREQ.
  - Check legality on the same edge:
    - OP_ENQ with q_full_i=1 -> RESP with err.
    - OP_DEQ with q_empty_i=1 -> RESP with err.
    - Otherwise -> ISSUE.
  - OP_REPL is always legal; on an empty queue it behaves as an enqueue and resp_o returns the all-ones MAX entry.
- ISSUE (1 cycle):
  - Assert exactly one of q_enq_o/q_deq_o/q_repl_o.
  - For OP_DEQ/OP_REPL, capture q_head_i into resp_q on this edge.
  - Go to BUSY.
- BUSY:
  - Strobes low.
  - Stay while q_rdy_i=0; on q_rdy_i=1 -> RESP.
  - The queue drops rdy the cycle after the strobe, so the first BUSY cycle always sees q_rdy_i=0.
- RESP (1 cycle):
  - done_o[win_idx]=1; err_o = rejection flag; resp_o = resp_q (0 for OP_ENQ or error).
  - Go to IDLE.
- busy_o=1 in every state except IDLE.
- Latency:
  - Accepted operation: done 3+B cycles after the IDLE accept edge, where B is the number of BUSY cycles.
  - Rejected operation: done on the cycle after accept.
- Requester protocol:
  - A requester may re-request on the cycle after its done_o.
  - req_i dropping mid-operation is ignored: the operation completes and done_o still pulses.
  - op_i/key_i changes after acceptance have no effect.
- Only one operation is outstanding at a time; no strobe is issued outside ISSUE.
- Unknown op encoding is treated as rejected (err_o=1).

Optional Feature:
- Macro QQ_ARB_STATS_EN.
- When defined, three 16-bit output ports are added: stat_enq_o, stat_deq_o, stat_err_o.
  - Each counts completed accepted enqueues, completed accepted dequeues/replaces, and rejections respectively, incremented on the RESP cycle.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- pq_pkg gains:
  - typedef enum logic [1:0] qq_op_t {OP_ENQ=2'b00, OP_DEQ=2'b01, OP_REPL=2'b10}
  - qq_arb_state_t {IDLE, ISSUE, BUSY, RESP}
  - MAX_KEY constant (all ones)
- kv_t is reused from pq_pkg.
- One sub-module, qq_rr_pick: combinational round-robin selector (req vector, rr_ptr -> valid, win_idx).

Test Plan:
- Reset then single OP_ENQ key 5 from req 0, queue model rdy low for 4 cycles:
  - One q_enq_o pulse with q_data_o=5.
  - done_o=4'b0001 with err_o=0 exactly 7 cycles after accept.
- Queue holding {3,7}, OP_DEQ from req 2:
  - resp_o=3 with done_o=4'b0100.
  - One q_deq_o pulse.
- q_full_i=1, OP_ENQ from req 1:
  - No strobe; done_o=4'b0010 with err_o=1 on the cycle after accept.
  - Same for OP_DEQ with q_empty_i=1.
- All four requesting continuously:
  - Grants in order 0,1,2,3,0.
  - Never two strobes in one cycle.
- Empty queue, OP_REPL key 9:
  - q_repl_o pulse; resp_o=all ones; subsequent OP_DEQ returns 9.
- rst_n=0 during BUSY:
  - Next cycle all outputs 0 and state IDLE.
  - No done_o for the abandoned operation.
  - rr_ptr restarts at 0.
